// File: rtl/md5_match.sv
// md5_match: tracks candidate order through the MD5 core, compares {C,D}
// against a loaded target, and queues hit indices for the host.
module md5_match #(
    parameter int PIPE_LAT   = 65,
    parameter int ID_W       = 48,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_in,
    input  logic [31:0]     c_in,
    input  logic [31:0]     d_in,
    input  logic            target_we,
    input  logic [63:0]     target_in,
    output logic            match_valid,
    input  logic            match_ready,
    output logic [ID_W-1:0] match_id,
    output logic            overflow,
    output logic [ID_W-1:0] checked_count,
    output logic            busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     PTR_ONE = 1;
    localparam logic [ID_W-1:0] CNT_ONE = 1;

    logic [PIPE_LAT-1:0] dly;
    logic [63:0]         target;
    logic [ID_W-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;

    logic slot_valid;
    logic hit;
    logic full;
    logic empty;
    logic pop;
    logic push;

    // Issue flags ride alongside the core; the head lines up with c_in/d_in.
    generate
        if (PIPE_LAT == 1) begin : g_one
            always_ff @(posedge clk or posedge reset) begin
                if (reset) dly <= '0;
                else       dly <= issue_in;
            end
        end else begin : g_many
            always_ff @(posedge clk or posedge reset) begin
                if (reset) dly <= '0;
                else       dly <= {dly[PIPE_LAT-2:0], issue_in};
            end
        end
    endgenerate

    assign slot_valid = dly[PIPE_LAT-1];
    assign hit        = slot_valid && ({c_in, d_in} == target);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && match_ready;
    // A full FIFO still accepts a hit when the head leaves in the same cycle.
    assign push  = hit && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target <= '0;
        end else if (target_we) begin
            target <= target_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checked_count <= '0;
        end else if (slot_valid) begin
            checked_count <= checked_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= checked_count;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (hit && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    assign match_valid = !empty;
    assign match_id    = mem[rd_ptr[AW-1:0]];
    assign busy        = |dly;

endmodule

// File: tb/tb_md5_match.sv
// Directed bench for md5_match: reset, single hit, ordering, overflow,
// full-with-pop and target switch, checked with immediate assertions.
module tb_md5_match;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_in;
    logic [31:0] c_in;
    logic [31:0] d_in;
    logic        target_we;
    logic [63:0] target_in;
    logic        match_valid;
    logic        match_ready;
    logic [47:0] match_id;
    logic        overflow;
    logic [47:0] checked_count;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [47:0] got [$];

    md5_match #(.PIPE_LAT(65), .ID_W(48), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .issue_in(issue_in),
        .c_in(c_in),
        .d_in(d_in),
        .target_we(target_we),
        .target_in(target_in),
        .match_valid(match_valid),
        .match_ready(match_ready),
        .match_id(match_id),
        .overflow(overflow),
        .checked_count(checked_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        issue_in    = 1'b0;
        c_in        = '0;
        d_in        = '0;
        target_we   = 1'b0;
        target_in   = '0;
        match_ready = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_target(input logic [63:0] t);
        target_in = t;
        target_we = 1'b1;
        tick();
        target_we = 1'b0;
    endtask

    task automatic drain(input int cycles);
        got.delete();
        match_ready = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            if (match_valid) got.push_back(match_id);
            tick();
        end
        match_ready = 1'b0;
    endtask

    initial begin
        do_reset();
        reset = 1'b1;
        tick();
        check("rst_valid", match_valid, 0);
        check("rst_id", match_id, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count", checked_count, 0);
        check("rst_busy", busy, 0);

        // Single hit: only candidate 4 sees the target value.
        do_reset();
        load_target(64'h0123456789ABCDEF);
        for (int i = 0; i < 80; i++) begin
            issue_in = (i < 10);
            c_in = (i == 69) ? 32'h01234567 : 32'h0;
            d_in = (i == 69) ? 32'h89ABCDEF : 32'h0;
            if (i == 1)  check("a_busy_up", busy, 1);
            if (i == 69) check("a_valid_pre", match_valid, 0);
            if (i == 70) begin
                check("a_valid", match_valid, 1);
                check("a_id", match_id, 4);
                check("a_count70", checked_count, 5);
            end
            if (i == 74) check("a_busy74", busy, 1);
            if (i == 75) begin
                check("a_busy75", busy, 0);
                check("a_count75", checked_count, 10);
            end
            tick();
        end
        drain(3);
        check("a_entries", got.size(), 1);
        if (got.size() > 0) check("a_drain_id", got[0], 4);
        check("a_empty", match_valid, 0);

        // Order with gaps; target 0 and c/d 0 makes every slot hit.
        do_reset();
        got.delete();
        match_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            issue_in = (i == 0) || (i == 1) || (i == 5) || (i == 9);
            if (i == 66) check("b_id66", match_id, 0);
            if (match_valid) got.push_back(match_id);
            tick();
        end
        match_ready = 1'b0;
        check("b_entries", got.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < got.size()) check("b_order", got[k], k);
        check("b_count", checked_count, 4);

        // Overflow: six hits into a four-deep FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 72; i++) begin
            issue_in = (i < 6);
            if (i == 69) begin
                check("c_full_valid", match_valid, 1);
                check("c_ovf_pre", overflow, 0);
            end
            if (i == 70) check("c_ovf_set", overflow, 1);
            tick();
        end
        check("c_count", checked_count, 6);
        match_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("c_drain_valid", match_valid, 1);
            check("c_drain_id", match_id, k);
            tick();
        end
        match_ready = 1'b0;
        check("c_empty", match_valid, 0);
        check("c_ovf_sticky", overflow, 1);

        // Full with a simultaneous pop: the new hit is kept.
        do_reset();
        for (int i = 0; i < 72; i++) begin
            issue_in = (i < 5);
            match_ready = (i == 69);
            if (i == 70) begin
                check("d_ovf", overflow, 0);
                check("d_head", match_id, 1);
            end
            tick();
        end
        drain(6);
        check("d_entries", got.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < got.size()) check("d_order", got[k], k + 1);
        check("d_ovf_end", overflow, 0);

        // Target switch at slot cycle 65.
        do_reset();
        load_target(64'hAAAA5555_12345678);
        for (int i = 0; i < 72; i++) begin
            issue_in  = (i < 4);
            target_we = (i == 65);
            target_in = 64'hFEDCBA98_76543210;
            if (i == 65 || i == 67) {c_in, d_in} = 64'hAAAA5555_12345678;
            else if (i == 66 || i == 68) {c_in, d_in} = 64'hFEDCBA98_76543210;
            else {c_in, d_in} = 64'h0;
            tick();
        end
        target_we = 1'b0;
        drain(5);
        check("e_entries", got.size(), 3);
        if (got.size() == 3) begin
            check("e_id0", got[0], 0);
            check("e_id1", got[1], 1);
            check("e_id2", got[2], 3);
        end

        // Reset mid-stream with entries queued and candidates in flight.
        do_reset();
        load_target(64'h1);
        d_in = 32'h1;
        for (int i = 0; i < 71; i++) begin
            issue_in = (i < 3) || (i >= 40 && i < 46);
            tick();
        end
        issue_in = 1'b0;
        check("f_pre_valid", match_valid, 1);
        check("f_pre_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("f_async_valid", match_valid, 0);
        check("f_async_id", match_id, 0);
        check("f_async_ovf", overflow, 0);
        check("f_async_count", checked_count, 0);
        check("f_async_busy", busy, 0);
        tick();
        reset = 1'b0;
        d_in = 32'h0;
        for (int i = 0; i < 100; i++) begin
            check("f_idle", {match_valid, overflow, busy, checked_count}, 0);
            tick();
        end
        // Target must have returned to 0: c/d of 0 now hits.
        issue_in = 1'b1;
        tick();
        issue_in = 1'b0;
        repeat (65) tick();
        check("f_tgt_valid", match_valid, 1);
        check("f_tgt_id", match_id, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md5_match.md
# md5_match

Downstream stage of the MD5 core. Tracks which candidate occupies each pipeline slot and compares the core's 64-bit {C,D} output against a loaded target. Every hit's candidate index is queued in a small FIFO and handed to the host/UART side through a valid/ready handshake. Candidate identity is never carried through the core; it is reconstructed from issue order.

## Interface
- PIPE_LAT, 65: cycles from a candidate's byte update entering the core to its c/d result appearing on c_in/d_in; ≥1.
- ID_W, 48: candidate index width; wraps modulo 2^ID_W.
- FIFO_DEPTH, 4: match FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- issue_in  in  1  a candidate was presented to the core this cycle.
- c_in  in  32  core C output.
- d_in  in  32  core D output.
- target_we  in  1  load target_in.
- target_in  in  64  target hash {C,D}, C in [63:32].
- match_valid  out  1  FIFO non-empty.
- match_ready  in  1  consumer accepts head entry.
- match_id  out  ID_W  candidate index at FIFO head.
- overflow  out  1  sticky: a hit was dropped.
- checked_count  out  ID_W  number of candidates compared so far.
- busy  out  1  at least one issued candidate not yet compared.

## Operation
- Delay line: PIPE_LAT-bit shift register of issue flags. issue_in enters at the tail each cycle; the head flag (`slot_valid`) is high exactly PIPE_LAT cycles after the matching issue_in.
- Candidate index: the k-th issue_in pulse after reset (k from 0) is candidate k. Order is preserved, so the index of the result at the head is checked_count. No per-slot ID storage.
- Compare: when slot_valid is high and {c_in,d_in} == target, record a hit with id = checked_count. checked_count increments by 1 on every slot_valid cycle, hit or not, and wraps at 2^ID_W.
- c_in/d_in are ignored when slot_valid is low.
- Target: a register loaded on target_we and used from the next cycle on. Candidates compared in the target_we cycle use the old target. Resets to 0.
- FIFO: push on hit, pop on match_valid && match_ready.
  - Full and hit with no pop: entry dropped, overflow set; overflow stays set until reset.
  - Full and hit with a simultaneous pop: both happen, no drop.
  - Pop when empty: no effect.
- match_id is the head entry. It is undefined when match_valid is low, but reset drives it to 0.
- busy = OR of the delay line.
- Reset mid-operation clears the delay line, counters, FIFO, overflow and target. In-flight candidates are lost, and the upstream generator must also be reset.

## Timing
- Reset values: match_valid 0, match_id 0, overflow 0, checked_count 0, busy 0.
- issue_in in cycle T → slot_valid in cycle T+PIPE_LAT → the hit is written into the FIFO at the end of that cycle. From cycle T+PIPE_LAT+1:
  - match_valid = 1.
  - checked_count is incremented.
  - overflow is set, if the entry was dropped.
- Handshake: the entry transfers in a cycle with match_valid && match_ready. match_valid and match_id hold steady while match_ready is low. Back-to-back pops give one entry per cycle.
- Throughput: one compare per cycle. Consecutive hits push on consecutive cycles.
- busy rises the cycle after the first issue_in and falls the cycle after the last slot_valid.
- Fully synchronous apart from the reset. No combinational path from inputs to outputs except none required.

## Test plan
- Reset/idle: assert reset mid-stream with 3 entries queued → all outputs 0 immediately; after release with no issue_in, outputs stay 0 indefinitely.
- Single hit, PIPE_LAT=65: target=0x0123456789ABCDEF; issue_in at cycles 10–19; drive c/d = 0x01234567/0x89ABCDEF only in cycle 10+65+4 → exactly one entry, match_id=4, match_valid rises at cycle 80; checked_count=10 at cycle 85.
- Order/gaps: issue_in at cycles 0,1,5,9; all four results hit → IDs 0,1,2,3 popped in order with match_ready held high, one per cycle.
- Overflow: FIFO_DEPTH=4, match_ready=0, 6 consecutive hits → 4 entries (IDs 0–3) retained, overflow=1 from the cycle after the 5th hit; later drain yields 0,1,2,3 and overflow stays 1.
- Full with simultaneous pop: FIFO full, hit in the same cycle as a pop → no drop, overflow=0, count remains 4, new ID at tail.
- Target change: target_we in cycle t, with slot_valid hits on the old target in cycle t and on the new target in cycle t+1 → both recorded; the old value presented in cycle t+1 is not recorded.
